cla_seq_adder_ctrl: RTL and testbench
=====================================

Name: cla_seq_adder_ctrl

Overview:
Sequential wide adder controller that time-multiplexes one 4-bit carry-lookahead slice over WIDTH/4 nibbles, least significant nibble first. A registered carry links the nibbles.
Operands are accepted on a valid/ready input handshake. The result is returned on a valid/ready output handshake.
It gives area-constrained paths a WIDTH-bit add without instantiating WIDTH/4 parallel slices.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and >= 4, otherwise elaboration error.
NIB, derived (WIDTH/4), nibble count; counter width is max(1, clog2(NIB)).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operands present.
in_ready  output  1  controller can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry into nibble 0.
op  input  1  0=add, 1=subtract; present only with SEQ_ADD_SUB_EN.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  result, registered.
cout  output  1  carry out of MSB nibble, registered.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, nibble index=0, carry reg=0, sum=0, cout=0, out_valid=0, busy=0. in_ready is 1 from the first edge with rst_n=1.
- Reset asserted mid-operation: aborts immediately; no partial result is ever presented.
- States are IDLE, RUN and DONE.
- IDLE:
  - Outputs: in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch a, b and cin into operand regs, index=0, go RUN.
  - sum/cout keep their previous values until RUN starts writing.
- RUN:
  - Outputs: in_ready=0, out_valid=0.
  - Each cycle, the slice adds nibble[index] of A and B with the carry reg.
  - The slice output is written to sum[4*index+3:4*index]; the carry reg takes the slice carry-out; index increments.
  - When index==NIB-1: cout takes the slice carry-out, index resets to 0, go DONE.
  - RUN lasts exactly NIB cycles.
- DONE:
  - Outputs: out_valid=1, in_ready=0.
  - sum and cout are held stable.
  - On out_ready: go IDLE.
- Timing:
  - Latency: out_valid rises NIB cycles after the acceptance edge.
  - Throughput: one op per NIB+2 cycles with out_ready tied high.
  - Next acceptance is earliest one cycle after the output handshake; there is no bypass.
- Changes to a, b or cin during RUN/DONE are ignored, since the operands are latched.
- in_valid during RUN/DONE is not accepted; the upstream must hold it.
- Carry-in of nibble 0 is the latched cin. Carry wraps out only through cout; no modular carry-around.
- sum and cout are meaningful only while out_valid=1.

Optional Feature:
Macro: SEQ_ADD_SUB_EN.
- Defined:
  - The op port exists and is latched with the operands.
  - op=1 computes A + ~B + 1: the B operand reg stores ~b and the initial carry is forced to 1, ignoring cin.
  - cout=1 means no borrow (A >= B unsigned).
  - op=0 behaves as plain add with cin.
- Undefined: no op port, add only; logic identical to the op=0 path.

Decomposition:
- Package seq_add_pkg:
  - NIB_W=4.
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - WIDTH legality check helper.
- Sub-module cla_slice4: purely combinational 4-bit carry-lookahead slice.
  - Inputs: x[3:0], y[3:0], ci.
  - Outputs: s[3:0], co.
  - Generate/propagate with full two-level lookahead for carries 1..3 and co.
- The controller instantiates exactly one cla_slice4 and contains the FSM, index counter, operand regs, carry reg and result regs.

Test Plan (WIDTH=16, NIB=4):
1. Hold rst_n=0 for 3 edges, then release -> sum=0, cout=0, out_valid=0, busy=0, in_ready=1 on the first released edge.
2. a=16'h1234, b=16'h4321, cin=0, accepted at edge E -> out_valid=1 after edge E+4, sum=16'h5555, cout=0; busy high from E+1 until the output handshake.
3. a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1 (carry propagates through all nibbles); then a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
4. Backpressure: out_ready=0 for 6 cycles with in_valid=1 and changing a/b -> out_valid, sum and cout hold; in_ready=0, no new acceptance; out_ready=1 -> IDLE next edge, in_ready=1.
5. Reset mid-op: accept a=16'h0F0F, b=16'h0101, drop rst_n for one edge at the 2nd RUN cycle -> next state IDLE, sum=0, cout=0, out_valid never asserts for the aborted op; a fresh op then completes correctly.
6. With SEQ_ADD_SUB_EN:
   - a=16'h0005, b=16'h0007, op=1 -> sum=16'hFFFE, cout=0.
   - a=16'h0007, b=16'h0005, op=1, cin=0 -> sum=16'h0002, cout=1 (cin ignored).
   - op=0 -> add results identical to scenario 2.

Source files
------------

// File: rtl/seq_add_pkg.sv
// Shared types and helpers for the sequential CLA adder controller.
package seq_add_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // A legal width is a whole number of nibbles, at least one.
    function automatic bit width_ok(input int unsigned w);
        return (w >= NIB_W) && ((w % NIB_W) == 0);
    endfunction

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead slice with two-level carry lookahead.
module cla_slice4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        w_g    = x & y;
        w_p    = x ^ y;
        w_c[0] = ci;
        w_c[1] = w_g[0] | (w_p[0] & ci);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & ci);
        co     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);
        s      = w_p ^ w_c;
    end

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder reusing one 4-bit CLA slice over WIDTH/4 nibbles,
// LS nibble first. Define SEQ_ADD_SUB_EN to add the op port (1 = subtract).
module cla_seq_adder_ctrl
    import seq_add_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_ADD_SUB_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    // Reject widths that are not a whole number of nibbles.
    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [NIB_W-1:0]   w_x;
    logic [NIB_W-1:0]   w_y;
    logic [NIB_W-1:0]   w_s;
    logic               w_co;

    // Select the current operand nibbles by index.
    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int i = 0; i < NIB; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_x = r_a[i*NIB_W +: NIB_W];
                w_y = r_b[i*NIB_W +: NIB_W];
            end
        end
    end

    cla_slice4 u_slice (
        .x  (w_x),
        .y  (w_y),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // Controller FSM with operand, carry, index and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
`ifdef SEQ_ADD_SUB_EN
                        // Subtract as A + ~B + 1; the forced carry replaces cin.
                        r_b        <= op ? ~b : b;
                        r_carry    <= op ? 1'b1 : cin;
`else
                        r_b        <= b;
                        r_carry    <= cin;
`endif
                        r_idx      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_sum[i*NIB_W +: NIB_W] <= w_s;
                        end
                    end
                    r_carry <= w_co;
                    if (r_idx == IDX_W'(NIB - 1)) begin
                        r_cout      <= w_co;
                        r_idx       <= '0;
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= IDX_W'(r_idx + 1'b1);
                    end
                end
                DONE: begin
                    // Ready again right after the output handshake.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign busy      = r_busy;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Scoreboard bench for cla_seq_adder_ctrl (WIDTH=16); subtract vectors need SEQ_ADD_SUB_EN.
module tb_cla_seq_adder_ctrl;

    localparam int unsigned WIDTH = 16;
    localparam int          NIB   = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             out_ready = 1'b1;
`ifdef SEQ_ADD_SUB_EN
    logic             op        = 1'b0;
`endif
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SEQ_ADD_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        int               acc;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: check latency on out_valid rise, pop and compare on each output handshake.
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                if (!prev_ov) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 at cycle %0d", cyc);
                end
            end else begin
                if (!prev_ov)
                    chk({sb[0].name, "_latency"}, 32'(cyc - sb[0].acc), 32'(NIB));
                if (out_ready) begin
                    e = sb.pop_front();
                    chk({e.name, "_sum"}, 32'(sum), 32'(e.s));
                    chk({e.name, "_cout"}, 32'(cout), 32'(e.c));
                    chk({e.name, "_busy"}, 32'(busy), 32'd1);
                end
            end
        end
        prev_ov = rst_n && (out_valid === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive one operation; push expected result at the acceptance edge.
    task automatic issue(input string nm, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, input logic iop, input logic [WIDTH-1:0] es,
                         input logic ec, output int acc);
        exp_t e;
        int   n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: got in_ready=%b expected 1", nm, in_ready);
        end
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        cin      = ic;
`ifdef SEQ_ADD_SUB_EN
        op       = iop;
`else
        if (iop) $display("note: op ignored in add-only build");
`endif
        @(posedge clk);
        #1;
        acc    = cyc;
        e.s    = es;
        e.c    = ec;
        e.acc  = acc;
        e.name = nm;
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk({nm, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int acc1;
        int acc2;
        int n;

        // Reset held for three edges, then the first released edge.
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic add; busy must be high during RUN.
        issue("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, acc1);
        tick();
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_in_ready", 32'(in_ready), 32'd0);
        wait_drain("add1");
        tick();
        chk("post_hs_busy", 32'(busy), 32'd0);

        // Full carry ripple through every nibble, then all ones plus cin.
        issue("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, acc1);
        wait_drain("add2");
        issue("add_ffff_ffff_c1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, acc1);
        wait_drain("add3");

        // Back-to-back throughput with out_ready high: NIB+2 cycles per op.
        issue("tp_a", 16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, acc1);
        issue("tp_b", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, acc2);
        chk("throughput", 32'(acc2 - acc1), 32'(NIB + 2));
        wait_drain("tp");

        // Backpressure: result holds and no new operands are taken.
        out_ready = 1'b0;
        issue("bp_8000_8000", 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, acc1);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            a        = 16'(i * 16'h1111);
            b        = 16'(16'hF0F0 ^ i);
            cin      = i[0];
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum_hold", 32'(sum), 32'h0001);
            chk("bp_cout_hold", 32'(cout), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_drain", 32'(sb.size()), 32'd0);

        // Reset during the second RUN cycle aborts without any output.
        in_valid = 1'b1;
        a        = 16'h0F0F;
        b        = 16'h0101;
        cin      = 1'b0;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        tick();
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (8) tick();
        issue("fresh_0f0f_0101", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, acc1);
        wait_drain("fresh");

`ifdef SEQ_ADD_SUB_EN
        // Subtraction: cout=1 means no borrow; cin is ignored.
        issue("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, acc1);
        wait_drain("sub1");
        issue("sub_7_5", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, acc1);
        wait_drain("sub2");
        issue("sub_7_5_cin1", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, acc1);
        wait_drain("sub3");
        issue("op0_add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, acc1);
        wait_drain("op0");
`endif

        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
